// File: rtl/map_scroll_ctrl_pkg.sv
// map_pkg: shared geometry constants, coordinate/index types and sequencer states
// for the platform map scroll logic.
package map_pkg;

    localparam int unsigned NUM_PLAT    = 32;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned SCROLL_LINE = 200;
    localparam int unsigned MAX_SCROLL  = 15;
    localparam int unsigned X_MAX       = 600;
    localparam int unsigned PLAT_IDX_W  = $clog2(NUM_PLAT);
    localparam logic [9:0]  LFSR_SEED   = 10'h2A5;

    typedef logic [10:0]           coord_t;
    typedef logic [PLAT_IDX_W-1:0] plat_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } map_scroll_state_t;

    function automatic logic [15:0] sat16_add(input logic [15:0] a, input coord_t b);
        logic [16:0] s;
        s = {1'b0, a} + {6'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/map_scroll_ctrl_if.sv
// map_scroll_ctrl_if: read-modify-write port into the platform table
// (registered read, single-cycle write strobe).
interface map_scroll_ctrl_if;
    import map_pkg::*;

    plat_idx_t plat_rd_idx;
    coord_t    plat_rd_x;
    coord_t    plat_rd_y;
    logic      plat_wr_en;
    plat_idx_t plat_wr_idx;
    coord_t    plat_wr_x;
    coord_t    plat_wr_y;

    modport master (
        output plat_rd_idx, plat_wr_en, plat_wr_idx, plat_wr_x, plat_wr_y,
        input  plat_rd_x, plat_rd_y
    );

    modport slave (
        input  plat_rd_idx, plat_wr_en, plat_wr_idx, plat_wr_x, plat_wr_y,
        output plat_rd_x, plat_rd_y
    );

endinterface

// File: rtl/map_scroll_ctrl_plat_lfsr.sv
// plat_lfsr: 10-bit Fibonacci LFSR (x^10 + x^7 + 1) that steps only when advance_i is high.
// Used for recycled platform X when PLAT_RANDOM_X_EN is defined.
module plat_lfsr
    import map_pkg::*;
#(
    parameter logic [9:0] SEED = LFSR_SEED
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       advance_i,
    output logic [9:0] lfsr_o
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/map_scroll_ctrl.sv
// map_scroll_ctrl: per-frame scroll sequencer; shifts every platform down and recycles wrapped ones.
// Define PLAT_RANDOM_X_EN to give recycled platforms an LFSR-derived X instead of keeping their own.
module map_scroll_ctrl
    import map_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              frame_tick,
    input  coord_t            Doodle_Y,
    map_scroll_ctrl_if.master plat,
    output coord_t            scroll_amt,
    output logic              busy,
    output logic              done,
    output logic [15:0]       score
);

    map_scroll_state_t state_q, state_d;
    plat_idx_t         idx_q, idx_d;
    coord_t            amt_q, amt_d;
    logic [15:0]       score_q, score_d;

    coord_t      calc_amt;
    coord_t      diff;
    logic [11:0] sum;
    logic        wrap;
    coord_t      new_x;

    always_comb begin
        calc_amt = '0;
        diff     = '0;
        if (Doodle_Y < coord_t'(SCROLL_LINE)) begin
            diff     = coord_t'(SCROLL_LINE) - Doodle_Y;
            calc_amt = (diff > coord_t'(MAX_SCROLL)) ? coord_t'(MAX_SCROLL) : diff;
        end
    end

    // 12-bit sum so a platform pushed past SCREEN_H is detected before truncation
    assign sum  = {1'b0, plat.plat_rd_y} + {1'b0, amt_q};
    assign wrap = (sum >= 12'(SCREEN_H));

`ifdef PLAT_RANDOM_X_EN
    logic [9:0] lfsr;
    logic       lfsr_adv;

    assign lfsr_adv = (state_q == ST_WRITE) && wrap;

    plat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .CLK       (CLK),
        .Reset     (Reset),
        .advance_i (lfsr_adv),
        .lfsr_o    (lfsr)
    );

    assign new_x = (lfsr >= 10'(X_MAX)) ? coord_t'(lfsr - 10'(X_MAX)) : coord_t'(lfsr);
`else
    assign new_x = plat.plat_rd_x;
`endif

    assign score_d = sat16_add(score_q, amt_q);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            amt_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            amt_q   <= amt_d;
            if (state_q == ST_DONE) begin
                score_q <= score_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        amt_d   = amt_q;
        unique case (state_q)
            ST_IDLE:  if (frame_tick) state_d = ST_CALC;
            ST_CALC: begin
                amt_d   = calc_amt;
                idx_d   = '0;
                state_d = (calc_amt == '0) ? ST_DONE : ST_READ;
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (idx_q == plat_idx_t'(NUM_PLAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        plat.plat_rd_idx = '0;
        plat.plat_wr_en  = 1'b0;
        plat.plat_wr_idx = '0;
        plat.plat_wr_x   = '0;
        plat.plat_wr_y   = '0;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state_q)
            ST_CALC: busy = 1'b1;
            ST_READ: begin
                busy             = 1'b1;
                plat.plat_rd_idx = idx_q;
            end
            ST_WRITE: begin
                busy             = 1'b1;
                plat.plat_wr_en  = 1'b1;
                plat.plat_wr_idx = idx_q;
                plat.plat_wr_y   = wrap ? coord_t'(sum - 12'(SCREEN_H)) : coord_t'(sum);
                plat.plat_wr_x   = wrap ? new_x : plat.plat_rd_x;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign scroll_amt = amt_q;
    assign score      = score_q;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// tb_map_scroll_ctrl: directed checks of map_scroll_ctrl against a behavioural platform table.
// Expected recycled X values follow PLAT_RANDOM_X_EN.
module tb_map_scroll_ctrl;
    import map_pkg::*;

`ifdef PLAT_RANDOM_X_EN
    localparam bit RAND_X = 1'b1;
`else
    localparam bit RAND_X = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic        frame_tick;
    coord_t      Doodle_Y;
    coord_t      scroll_amt;
    logic        busy;
    logic        done;
    logic [15:0] score;

    map_scroll_ctrl_if pif ();

    map_scroll_ctrl dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .Doodle_Y   (Doodle_Y),
        .plat       (pif.master),
        .scroll_amt (scroll_amt),
        .busy       (busy),
        .done       (done),
        .score      (score)
    );

    always #5 CLK = ~CLK;

    // platform table model: registered read, write port plus a bench-side loader
    coord_t    mem_x [NUM_PLAT];
    coord_t    mem_y [NUM_PLAT];
    logic      ld_en;
    plat_idx_t ld_idx;
    coord_t    ld_x, ld_y;

    always @(posedge CLK) begin
        pif.plat_rd_x <= mem_x[pif.plat_rd_idx];
        pif.plat_rd_y <= mem_y[pif.plat_rd_idx];
        if (pif.plat_wr_en) begin
            mem_x[pif.plat_wr_idx] <= pif.plat_wr_x;
            mem_y[pif.plat_wr_idx] <= pif.plat_wr_y;
        end else if (ld_en) begin
            mem_x[ld_idx] <= ld_x;
            mem_y[ld_idx] <= ld_y;
        end
    end

    int     cyc = 0;
    logic   mon_clr;
    int     wr_cnt, done_cnt, done_cyc;
    coord_t wlog_x [NUM_PLAT];
    coord_t wlog_y [NUM_PLAT];
    int     wlog_cyc [NUM_PLAT];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (mon_clr) begin
            wr_cnt   <= 0;
            done_cnt <= 0;
        end else begin
            if (pif.plat_wr_en) begin
                wr_cnt                     <= wr_cnt + 1;
                wlog_x[pif.plat_wr_idx]   <= pif.plat_wr_x;
                wlog_y[pif.plat_wr_idx]   <= pif.plat_wr_y;
                wlog_cyc[pif.plat_wr_idx] <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_one(input int k, input coord_t y);
        ld_en  = 1'b1;
        ld_idx = plat_idx_t'(k);
        ld_x   = coord_t'(k * 10 + 1);
        ld_y   = y;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic load_all(input coord_t y);
        for (int k = 0; k < NUM_PLAT; k++) load_one(k, y);
    endtask

    task automatic start_frame(input coord_t dy, output int t0);
        Doodle_Y   = dy;
        frame_tick = 1'b1;
        mon_clr    = 1'b1;
        t0         = cyc;
        step();
        frame_tick = 1'b0;
        mon_clr    = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int tk1, input int tk2);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != 0) break;
            frame_tick = ((cyc - t0) == tk1) || ((cyc - t0) == tk2);
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic quick_frame(input string tag, input coord_t dy, input int exp_amt, input int exp_score);
        int t0;
        start_frame(dy, t0);
        wait_done(t0, -1, -1);
        chk({tag, "_done"}, 32'(done_cnt), 1);
        chk({tag, "_amt"}, 32'(scroll_amt), 32'(exp_amt));
        chk({tag, "_score"}, 32'(score), 32'(exp_score));
    endtask

    initial begin
        int t0;
        int ey, ex;
        Reset = 1'b1; frame_tick = 1'b0; Doodle_Y = '0;
        ld_en = 1'b0; ld_idx = '0; ld_x = '0; ld_y = '0; mon_clr = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        step();
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_amt",   32'(scroll_amt), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_wr_en", 32'(pif.plat_wr_en), 0);
        chk("rst_rdidx", 32'(pif.plat_rd_idx), 0);

        // non-scrolling frame
        load_all(11'd100);
        start_frame(11'd300, t0);
        chk("ns_busy_t1", 32'(busy), 1);
        wait_done(t0, -1, -1);
        chk("ns_done_cnt", 32'(done_cnt), 1);
        chk("ns_done_at",  32'(done_cyc - t0), 2);
        chk("ns_writes",   32'(wr_cnt), 0);
        chk("ns_amt",      32'(scroll_amt), 0);
        chk("ns_score",    32'(score), 0);

        // scroll by 10, no wrap
        start_frame(11'd190, t0);
        step();
        chk("s10_amt_t2",  32'(scroll_amt), 10);
        chk("s10_busy_t2", 32'(busy), 1);
        wait_done(t0, -1, -1);
        chk("s10_done_cnt", 32'(done_cnt), 1);
        chk("s10_done_at",  32'(done_cyc - t0), 66);
        chk("s10_writes",   32'(wr_cnt), 32);
        chk("s10_first_wr", 32'(wlog_cyc[0] - t0), 3);
        chk("s10_last_wr",  32'(wlog_cyc[NUM_PLAT-1] - t0), 65);
        chk("s10_busy_end", 32'(busy), 0);
        chk("s10_score",    32'(score), 10);
        for (int k = 0; k < NUM_PLAT; k++) begin
            chk("s10_wr_y", 32'(wlog_y[k]), 110);
            chk("s10_wr_x", 32'(wlog_x[k]), 32'(k * 10 + 1));
        end

        // clamped scroll with wrap boundaries
        load_all(11'd0);
        load_one(5, 11'd470);
        load_one(6, 11'd465);
        load_one(7, 11'd464);
        start_frame(11'd50, t0);
        wait_done(t0, -1, -1);
        chk("clamp_amt",    32'(scroll_amt), 15);
        chk("clamp_writes", 32'(wr_cnt), 32);
        chk("clamp_score",  32'(score), 25);
        for (int k = 0; k < NUM_PLAT; k++) begin
            ey = (k == 5) ? 5 : (k == 6) ? 0 : (k == 7) ? 479 : 15;
            ex = (RAND_X && k == 5) ? 77 : (RAND_X && k == 6) ? 331 : k * 10 + 1;
            chk("clamp_wr_y", 32'(wlog_y[k]), 32'(ey));
            chk("clamp_wr_x", 32'(wlog_x[k]), 32'(ex));
        end

        // stray ticks mid-sequence
        load_all(11'd100);
        start_frame(11'd190, t0);
        wait_done(t0, 10, 40);
        repeat (5) step();
        chk("tick_done_cnt", 32'(done_cnt), 1);
        chk("tick_writes",   32'(wr_cnt), 32);
        chk("tick_busy",     32'(busy), 0);
        chk("tick_score",    32'(score), 35);

        // scroll-line boundaries
        quick_frame("y200", 11'd200, 0, 35);
        quick_frame("y199", 11'd199, 1, 36);
        quick_frame("y184", 11'd184, 15, 51);

        // reset mid-sequence
        load_all(11'd100);
        start_frame(11'd190, t0);
        for (int i = 0; i < 40 && (cyc - t0) < 20; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_mid_writes", 32'(wr_cnt), 9);
        repeat (10) step();
        chk("rst_mid_writes_after", 32'(wr_cnt), 9);
        chk("rst_mid_busy",  32'(busy), 0);
        chk("rst_mid_score", 32'(score), 0);
        chk("rst_mid_amt",   32'(scroll_amt), 0);
        chk("rst_mid_mem_y9", 32'(mem_y[9]), 100);
        chk("rst_mid_mem_y8", 32'(mem_y[8]), 110);

        // LFSR restarts from seed after reset
        load_all(11'd0);
        load_one(0, 11'd470);
        start_frame(11'd50, t0);
        wait_done(t0, -1, -1);
        chk("seed_wr_y", 32'(wlog_y[0]), 5);
        chk("seed_wr_x", 32'(wlog_x[0]), RAND_X ? 32'd77 : 32'd1);
        chk("seed_score", 32'(score), 15);

        // score saturation from a preset near the top
        force dut.score_q = 16'd65500;
        step();
        release dut.score_q;
        quick_frame("sat1", 11'd50, 15, 65515);
        quick_frame("sat2", 11'd50, 15, 65530);
        quick_frame("sat3", 11'd50, 15, 65535);
        quick_frame("sat4", 11'd50, 15, 65535);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
